// File: rtl/cic_comb.sv
// Five-stage CIC comb chain (differential delay 1) with order tap, rounded right shift and output narrowing.
// Define CIC_COMB_SAT_EN to clamp out-of-range results instead of wrapping them.
module cic_comb #(
  parameter int EXTBITWIDTH = 43,
  parameter int OUTBITWIDTH = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4:0]                    cic_order,
  input  logic [5:0]                    out_shift,
  input  logic [EXTBITWIDTH-1:0]        din,
  input  logic                          din_flag,
  output logic signed [OUTBITWIDTH-1:0] dout,
  output logic                          dout_flag
);

  localparam int STAGES = 5;
  localparam logic [5:0] MAX_SHIFT = 6'(EXTBITWIDTH - 1);

  logic [EXTBITWIDTH-1:0] stage_in [STAGES];
  logic [STAGES-1:0]      stage_in_v;
  logic [EXTBITWIDTH-1:0] y [STAGES];
  logic [EXTBITWIDTH-1:0] z [STAGES];
  logic [STAGES-1:0]      v;

  logic [EXTBITWIDTH-1:0]        sel;
  logic                          sel_v;
  logic [5:0]                    shift_eff;
  logic signed [EXTBITWIDTH:0]   round_add;
  logic signed [EXTBITWIDTH:0]   sum;
  logic [OUTBITWIDTH-1:0]        narrowed;

  always_comb begin
    stage_in[0]   = din;
    stage_in_v[0] = din_flag;
    for (int k = 1; k < STAGES; k++) begin
      stage_in[k]   = y[k-1];
      stage_in_v[k] = v[k-1];
    end
  end

  // Plain modular subtraction: integrator overflow must be left to cancel here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        y[k] <= '0;
        z[k] <= '0;
      end
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v[k] <= stage_in_v[k];
        if (stage_in_v[k]) begin
          y[k] <= stage_in[k] - z[k];
          z[k] <= stage_in[k];
        end
      end
    end
  end

  always_comb begin
    case (cic_order)
      5'd4:    begin sel = y[3]; sel_v = v[3]; end
      5'd5:    begin sel = y[4]; sel_v = v[4]; end
      default: begin sel = y[2]; sel_v = v[2]; end
    endcase
  end

  // One guard bit keeps the round-half-up addition from overflowing.
  always_comb begin
    shift_eff = (out_shift > MAX_SHIFT) ? MAX_SHIFT : out_shift;
    round_add = '0;
    if (shift_eff != 6'd0) round_add[shift_eff - 6'd1] = 1'b1;
    sum = {sel[EXTBITWIDTH-1], sel} + round_add;
  end

`ifdef CIC_COMB_SAT_EN
  logic signed [EXTBITWIDTH:0] scaled;
  logic [EXTBITWIDTH-OUTBITWIDTH+1:0] upper;

  always_comb begin
    scaled = sum >>> shift_eff;
    upper  = scaled[EXTBITWIDTH:OUTBITWIDTH-1];
    if ((&upper) || !(|upper))
      narrowed = scaled[OUTBITWIDTH-1:0];
    else if (scaled[EXTBITWIDTH])
      narrowed = {1'b1, {(OUTBITWIDTH-1){1'b0}}};
    else
      narrowed = {1'b0, {(OUTBITWIDTH-1){1'b1}}};
  end
`else
  always_comb begin
    narrowed = OUTBITWIDTH'(sum >>> shift_eff);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout      <= '0;
      dout_flag <= 1'b0;
    end else begin
      dout_flag <= sel_v;
      if (sel_v) dout <= narrowed;
    end
  end

endmodule

// File: tb/tb_cic_comb.sv
// Directed bench for cic_comb: step, latency/throughput, wrap, rounding, narrowing and mid-stream reset.
// A 16-bit-output instance shares the stimulus for the narrowing checks (CIC_COMB_SAT_EN aware).
module tb_cic_comb;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [4:0]         cic_order = 5'd3;
  logic [5:0]         out_shift = 6'd0;
  logic [42:0]        din = '0;
  logic               din_flag = 1'b0;
  logic signed [23:0] dout;
  logic               dout_flag;
  logic signed [15:0] dout16;
  logic               dout16_flag;

  int vec_count  = 0;
  int miss_count = 0;
  longint got_q[$];
  longint got16_q[$];
  longint exp_q[$];

  cic_comb #(.EXTBITWIDTH(43), .OUTBITWIDTH(24)) dut (
    .clk(clk), .rst(rst), .cic_order(cic_order), .out_shift(out_shift),
    .din(din), .din_flag(din_flag), .dout(dout), .dout_flag(dout_flag)
  );

  cic_comb #(.EXTBITWIDTH(43), .OUTBITWIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .cic_order(cic_order), .out_shift(out_shift),
    .din(din), .din_flag(din_flag), .dout(dout16), .dout_flag(dout16_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dout_flag) got_q.push_back(longint'(dout));
    if (dout16_flag) got16_q.push_back(longint'(dout16));
  end

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyReset(input logic [4:0] order, input logic [5:0] shift);
    @(negedge clk);
    rst = 1'b0;
    cic_order = order;
    out_shift = shift;
    din_flag = 1'b0;
    din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    got16_q.delete();
  endtask

  task automatic applyStimulus(input logic [42:0] value, input int gap);
    din = value;
    din_flag = 1'b1;
    @(negedge clk);
    din_flag = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic runStep(input int zeros, input longint level, input int ones, input int gap);
    for (int i = 0; i < zeros; i++) applyStimulus(43'd0, gap);
    for (int i = 0; i < ones; i++) applyStimulus(43'(level), gap);
    repeat (8) @(negedge clk);
  endtask

  task automatic checkSeq(input string tag, input bit use16);
    longint q[$];
    longint got;
    if (use16) q = got16_q;
    else q = got_q;
    checkOutput({tag, "_len"}, longint'(q.size()), longint'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < q.size()) ? q[i] : -64'sd999999999;
      checkOutput($sformatf("%s[%0d]", tag, i), got, exp_q[i]);
    end
  endtask

  initial begin
    #2;
    checkOutput("reset_dout", longint'(dout), 0);
    checkOutput("reset_flag", longint'(dout_flag), 0);

    applyReset(5'd3, 6'd0);
    runStep(4, 1000, 5, 4);
    exp_q = '{0, 0, 0, 0, 1000, -2000, 1000, 0, 0};
    checkSeq("step_o3", 1'b0);

    applyReset(5'd5, 6'd0);
    runStep(0, 1000, 6, 2);
    exp_q = '{1000, -4000, 6000, -4000, 1000, 0};
    checkSeq("step_o5", 1'b0);

    applyReset(5'd9, 6'd0);
    runStep(0, 1000, 4, 1);
    exp_q = '{1000, -2000, 1000, 0};
    checkSeq("step_inv_order", 1'b0);

    for (int n = 3; n <= 5; n++) begin
      applyReset(5'(n), 6'd0);
      @(negedge clk);
      din = 43'd7;
      din_flag = 1'b1;
      for (int k = 0; k <= n; k++) begin
        @(negedge clk);
        checkOutput($sformatf("lat_o%0d_c%0d", n, k), longint'(dout_flag), (k == n) ? 1 : 0);
      end
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        checkOutput($sformatf("thru_o%0d_c%0d", n, k), longint'(dout_flag), 1);
      end
      din_flag = 1'b0;
      repeat (8) @(negedge clk);
    end

    // Stage 1 sees +2 across the 43-bit wrap; y3 = A, 4, A-4, 2, 0 modulo 2^43.
    applyReset(5'd3, 6'd0);
    applyStimulus(43'h3FFFFFFFFFF, 1);
    for (int i = 0; i < 4; i++) applyStimulus(43'h40000000001, 1);
    repeat (8) @(negedge clk);
    exp_q = '{-1, 4, -5, 2, 0};
    checkSeq("wrap", 1'b0);

    applyReset(5'd3, 6'd4);
    runStep(0, 1000, 4, 3);
    exp_q = '{63, -125, 63, 0};
    checkSeq("round_s4", 1'b0);

    applyReset(5'd3, 6'd1);
    runStep(0, 1000, 3, 1);
    exp_q = '{500, -1000, 500};
    checkSeq("round_s1", 1'b0);

    applyReset(5'd3, 6'd0);
    runStep(0, 40000, 3, 2);
    exp_q = '{40000, -80000, 40000};
    checkSeq("wide_40000", 1'b0);
`ifdef CIC_COMB_SAT_EN
    exp_q = '{32767, -32768, 32767};
`else
    exp_q = '{-25536, -14464, -25536};
`endif
    checkSeq("narrow16", 1'b1);

    applyReset(5'd3, 6'd0);
    for (int i = 0; i < 5; i++) begin
      din = 43'd1000;
      din_flag = 1'b1;
      @(negedge clk);
    end
    checkOutput("pre_rst_flag", longint'(dout_flag), 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_dout", longint'(dout), 0);
    checkOutput("async_rst_flag", longint'(dout_flag), 0);
    din_flag = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    got16_q.delete();
    runStep(0, 1000, 4, 1);
    exp_q = '{1000, -2000, 1000, 0};
    checkSeq("post_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/cic_comb.md
# cic_comb

Comb section of the DDC CIC decimation filter, directly downstream of `cic_decimator`. Consumes the decimated integrator sample (`dout`/`dout_flag` of `cic_decimator`), runs a 5-deep chain of first-order comb stages (differential delay 1) at the decimated rate, and taps the stage selected by `cic_order`. The selected result is scaled by a programmable right shift with rounding, then narrowed to the output width with optional saturation. Output feeds the compensation FIR.

## Interface
- `EXTBITWIDTH`, 43: internal comb word width; must match `cic_decimator`.
- `OUTBITWIDTH`, 24: output sample width, signed; must be less than `EXTBITWIDTH`.
- `clk`  in  1  sample clock, same as `cic_decimator`.
- `rst`  in  1  async active-low reset.
- `cic_order`  in  5  filter order; 3, 4 or 5 valid; any other value behaves as 3.
- `out_shift`  in  6  arithmetic right shift; values above `EXTBITWIDTH-1` behave as `EXTBITWIDTH-1`.
- `din`  in  `EXTBITWIDTH`  decimated integrator sample, two's complement.
- `din_flag`  in  1  `din` valid; one-cycle pulse, may be high on consecutive cycles.
- `dout`  out  `OUTBITWIDTH`  filtered, scaled sample, signed; registered.
- `dout_flag`  out  1  `dout` valid, one-cycle pulse; registered.

Reset and clocking are fixed: one clock; reset is asynchronous and active-low.

## Operation
- Comb stage k, for k = 1..5:
  - Input `x1 = din`; `xk = y(k-1)`.
  - On edge with `v(k-1)`:
    - `yk <= xk - zk`
    - `zk <= xk`
    - `vk <= 1`
  - Otherwise `vk <= 0`; `yk` and `zk` hold.
  - `v0 = din_flag`.
- All arithmetic is modulo 2^`EXTBITWIDTH`. Wrap-around is required and must not be detected or clipped, because CIC integrator overflow cancels in the combs.
- All five stages always run, whatever the order setting.
- Order tap: `sel = y3/v3`, `y4/v4` or `y5/v5` per `cic_order`, where 3 also covers invalid values.
- Scaling on `sel` valid, in one registered step:
  - `s = (sel + (out_shift>0 ? 1<<(out_shift-1) : 0)) >>> out_shift`.
  - The sum is computed in `EXTBITWIDTH+1` bits, sign-extended, so the round-half-up term cannot overflow.
  - Narrow `s` to `OUTBITWIDTH` as set by the macro in Configuration.
  - `dout <= result`; `dout_flag <= 1`.
  - Without valid: `dout` holds its value and `dout_flag <= 0`.
- `cic_order` or `out_shift` change mid-stream:
  - Takes effect from the next sample leaving the tap or scaler.
  - The comb state is not flushed.
  - The first outputs after an order change are transient; no masking.
- Reset, including mid-operation: all `zk`, `yk`, `vk`, `dout` and `dout_flag` clear to 0. In-flight samples are discarded.

## Timing
- Reset values: `dout = 0`, `dout_flag = 0`; all internal registers 0.
- Latency, with `din_flag` sampled high at edge E:
  - Stage k result is registered at edge E+k-1.
  - `dout`/`dout_flag` are registered at edge E+N, where N = effective order.
  - So `dout_flag` is high during the cycle following edge E+N: latency N cycles.
- Throughput: one sample per clock; fully pipelined, no stalls.
- Back-to-back `din_flag` produces back-to-back `dout_flag`.
- No backpressure. The downstream stage must accept every `dout_flag` pulse.
- `din_flag` spacing follows the decimation factor; the block places no spacing requirement.

## Configuration
- `CIC_COMB_SAT_EN` defined:
  - If `s` exceeds the signed `OUTBITWIDTH` range, `dout` clamps to `2^(OUTBITWIDTH-1)-1` or `-2^(OUTBITWIDTH-1)`.
- Not defined:
  - `dout = s[OUTBITWIDTH-1:0]`, plain truncation with wrap.
  - No compare logic is synthesized.

## Test plan
1. Step response. `OUTBITWIDTH=24`, order 3, shift 0. `din` = 0 for 4 samples, then 1000 constant, `din_flag` every 4th cycle. Required `dout` on successive flags: 0…, 1000, -2000, 1000, 0, 0.
2. Latency and throughput. Order 3, 4, 5, `din_flag` high on consecutive cycles:
   - `dout_flag` first rises exactly 3, 4 and 5 cycles after the first sampled `din_flag`.
   - It then stays high on every cycle with no gaps.
3. Wrap-around. Order 3, shift 0, `din` = 0x3FFFFFFFFFF, then 0x40000000001 (43-bit wrap). Stage-1 difference must be +2. The `dout` sequence must match a 43-bit modular reference model.
4. Rounding. Order 3, shift 4, step of 1000. Required `dout`: 63, -125, 63, 0.
5. Saturation, `OUTBITWIDTH=16`, shift 0, step of 40000:
   - With `CIC_COMB_SAT_EN`: 32767, -32768, 32767.
   - Without the macro: -25536, -14464, -25536.
6. Reset mid-stream. Assert `rst` for 2 cycles while samples are in flight:
   - `dout` and `dout_flag` go to 0 asynchronously.
   - The first post-reset step of 1000 gives 1000, -2000, 1000, with no residue from pre-reset state.
